adc_hex_formatter: RTL and testbench

- Upstream feeder for the UART transmitter in the ADC demo. Accepts ADC samples over a valid/ready interface and buffers them in a small FIFO.
- Renders each sample as upper-case ASCII hex digits followed by a line terminator, then drives the transmitter's sendRequest/sendData/sendComplete byte handshake one character at a time.
- Output is a human-readable sample stream on the serial terminal.

---
 rtl/adc_demo_pkg.sv | 24 ++
 rtl/sample_fifo.sv | 56 +++++
 rtl/adc_hex_formatter.sv | 142 ++++++++++++++
 tb/tb_adc_hex_formatter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_demo_pkg.sv
// Shared definitions for the ADC demo: ASCII constants, formatter FSM states
// and the nibble-to-hex-character helper.
package adc_demo_pkg;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_A  = 8'h41;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    REQ,
    RELEASE
  } fmt_state_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return CHAR_0 + {4'd0, nib};
    end
    return CHAR_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered occupancy count; writes while full
// and reads while empty are ignored.
module sample_fifo #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic                          wr_en_i,
  input  logic [SAMPLE_WIDTH-1:0]       wr_data_i,
  input  logic                          rd_en_i,
  output logic [SAMPLE_WIDTH-1:0]       rd_data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  logic [SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q;
  logic [AW-1:0]           rd_ptr_q;
  logic [AW:0]             count_q;
  logic                    do_wr;
  logic                    do_rd;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/adc_hex_formatter.sv
// Buffers ADC samples and streams each one as upper-case hex plus a line
// terminator over the UART byte handshake. Define ADC_HEX_CRLF_EN for CR LF.
module adc_hex_formatter #(
  parameter int SAMPLE_WIDTH = 12,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    resetN,
  input  logic                    sampleValid,
  input  logic [SAMPLE_WIDTH-1:0] sampleData,
  output logic                    sampleReady,
  output logic                    sendRequest,
  output logic [7:0]              sendData,
  input  logic                    sendComplete,
  output logic                    overflow,
  output logic                    busy
);

  import adc_demo_pkg::*;

  localparam int NDIG = (SAMPLE_WIDTH + 3) / 4;
  localparam int PW   = 4 * NDIG;
  localparam int IW   = 5;
`ifdef ADC_HEX_CRLF_EN
  localparam int SEQ_LEN = NDIG + 2;
`else
  localparam int SEQ_LEN = NDIG + 1;
`endif
  localparam logic [IW-1:0] LAST_IDX = IW'(SEQ_LEN - 1);

  fmt_state_t                state_q;
  logic [IW-1:0]             char_idx_q;
  logic                      send_request_q;
  logic [7:0]                send_data_q;
  logic                      overflow_q;
  logic [SAMPLE_WIDTH-1:0]   shadow_q;
  logic [PW-1:0]             padded;
  logic [3:0]                nib;
  logic [7:0]                char_d;

  logic                      fifo_pop;
  logic [SAMPLE_WIDTH-1:0]   fifo_rd_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  sample_fifo #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetN   (resetN),
    .wr_en_i  (sampleValid),
    .wr_data_i(sampleData),
    .rd_en_i  (fifo_pop),
    .rd_data_o(fifo_rd_data),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

  assign fifo_pop    = (state_q == IDLE) && !fifo_empty;
  assign sampleReady = !fifo_full;
  assign sendRequest = send_request_q;
  assign sendData    = send_data_q;
  assign overflow    = overflow_q;
  assign busy        = (fifo_count != '0) || (state_q != IDLE);
  assign padded      = PW'(shadow_q);

  // Character for the current index: digits MS nibble first, then terminator.
  always_comb begin
    nib = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (char_idx_q == IW'(NDIG - 1 - k)) nib = padded[4*k +: 4];
    end
    char_d = nibble_to_ascii(nib);
    if (char_idx_q >= IW'(NDIG)) begin
`ifdef ADC_HEX_CRLF_EN
      char_d = (char_idx_q == IW'(NDIG)) ? CHAR_CR : CHAR_LF;
`else
      char_d = CHAR_LF;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_pop) shadow_q <= fifo_rd_data;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      overflow_q <= 1'b0;
    end else if (sampleValid && fifo_full) begin
      overflow_q <= 1'b1;
    end
  end

  // LOAD holds off the request while sendComplete is still high, which also
  // covers a byte the transmitter is finishing from before a reset.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      char_idx_q     <= '0;
      send_request_q <= 1'b0;
      send_data_q    <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            char_idx_q <= '0;
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          send_data_q <= char_d;
          if (!sendComplete) begin
            send_request_q <= 1'b1;
            state_q        <= REQ;
          end
        end
        REQ: begin
          if (sendComplete) begin
            send_request_q <= 1'b0;
            state_q        <= RELEASE;
          end
        end
        RELEASE: begin
          if (!sendComplete) begin
            if (char_idx_q == LAST_IDX) begin
              state_q <= IDLE;
            end else begin
              char_idx_q <= char_idx_q + 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_hex_formatter.sv
// Randomized bench for adc_hex_formatter with a transmitter model and a
// string-level reference of the expected character stream.
module tb_adc_hex_formatter;

  localparam int SW = 12;
  localparam int FD = 4;
  localparam int ND = (SW + 3) / 4;

  logic          clock;
  logic          resetN;
  logic          sampleValid;
  logic [SW-1:0] sampleData;
  logic          sampleReady;
  logic          sendRequest;
  logic [7:0]    sendData;
  logic          sendComplete;
  logic          overflow;
  logic          busy;

  int n_chk = 0;
  int n_err = 0;
  int req_dly = 20;
  int rel_dly = 5;
  int stab_err = 0;
  int viol = 0;
  logic xmit_active = 1'b0;
  logic req_prev = 1'b0;

  logic [7:0]    rx_q[$];
  logic [7:0]    exp_q[$];
  logic [SW-1:0] tx_vals[$];
  logic          rdy_q[$];

  adc_hex_formatter #(.SAMPLE_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
    .clock       (clock),
    .resetN      (resetN),
    .sampleValid (sampleValid),
    .sampleData  (sampleData),
    .sampleReady (sampleReady),
    .sendRequest (sendRequest),
    .sendData    (sendData),
    .sendComplete(sendComplete),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Transmitter model: captures a byte on a fresh request, completes after
  // req_dly cycles, clears sendComplete rel_dly cycles after the request drops.
  initial begin
    logic [7:0] cap;
    sendComplete = 1'b0;
    forever begin
      @(negedge clock);
      if (sendRequest && !sendComplete) begin
        xmit_active = 1'b1;
        cap = sendData;
        rx_q.push_back(cap);
        for (int k = 0; k < req_dly; k++) begin
          @(negedge clock);
          if (sendRequest && sendData != cap) stab_err++;
        end
        @(posedge clock);
        #1 sendComplete = 1'b1;
        while (sendRequest) @(negedge clock);
        repeat (rel_dly) @(posedge clock);
        #1 sendComplete = 1'b0;
        xmit_active = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    req_prev <= sendRequest;
    if (sendRequest && !req_prev && sendComplete) viol <= viol + 1;
  end

  task automatic add_exp(input logic [SW-1:0] s);
    for (int i = ND - 1; i >= 0; i--) begin
      int n;
      n = (int'(s) >> (4 * i)) & 15;
      exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
    end
`ifdef ADC_HEX_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  task automatic send_vals();
    rdy_q.delete();
    foreach (tx_vals[i]) begin
      @(negedge clock);
      sampleValid = 1'b1;
      sampleData  = tx_vals[i];
      rdy_q.push_back(sampleReady);
    end
    @(negedge clock);
    sampleValid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while ((rx_q.size() < exp_q.size() || xmit_active) && cyc < 20000) begin
      @(negedge clock);
      cyc++;
    end
    chk({tag, "_timeout"}, 32'(cyc >= 20000), 0);
    repeat (3) @(negedge clock);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
    chk({tag, "_stable"}, stab_err, 0);
    chk({tag, "_reqorder"}, viol, 0);
    rx_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    logic [SW-1:0] s;
    resetN      = 1'b0;
    sampleValid = 1'b0;
    sampleData  = '0;
    repeat (3) @(negedge clock);
    chk("rst_req", sendRequest, 0);
    chk("rst_data", sendData, 8'h00);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", sampleReady, 1);
    resetN = 1'b1;
    repeat (2) @(negedge clock);

    // Single known sample
    tx_vals.delete();
    tx_vals.push_back(12'hA3F);
    send_vals();
    add_exp(12'hA3F);
    chk("a3f_first_exp", exp_q[0], 8'h41);
    wait_done("a3f");

    // Boundary values back to back
    tx_vals.delete();
    tx_vals.push_back(12'h000);
    tx_vals.push_back(12'hFFF);
    send_vals();
    add_exp(12'h000);
    add_exp(12'hFFF);
    wait_done("bound");

    // Randomized batches that never fill the FIFO
    for (int b = 0; b < 6; b++) begin
      req_dly = $urandom_range(1, 25);
      rel_dly = $urandom_range(0, 10);
      tx_vals.delete();
      for (int i = 0; i < $urandom_range(1, FD); i++) begin
        s = SW'($urandom);
        tx_vals.push_back(s);
        add_exp(s);
      end
      send_vals();
      foreach (rdy_q[i]) chk($sformatf("rnd%0d_rdy%0d", b, i), rdy_q[i], 1);
      wait_done($sformatf("rnd%0d", b));
    end

    // Handshake stall: sendComplete lingers after the request drops
    req_dly = 20;
    rel_dly = 50;
    s = SW'($urandom);
    tx_vals.delete();
    tx_vals.push_back(s);
    add_exp(s);
    send_vals();
    wait_done("stall");

    // Burst of six: first drains into the FSM, four fill the FIFO, sixth drops
    req_dly = 20;
    rel_dly = 5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (i == 2) chk("burst_cnt_wr_pop", dut.u_fifo.count_o, 1);
      s = SW'($urandom);
      sampleValid = 1'b1;
      sampleData  = s;
      chk($sformatf("burst_rdy%0d", i), sampleReady, (i < 5) ? 1 : 0);
      if (i < 5) add_exp(s);
    end
    @(negedge clock);
    sampleValid = 1'b0;
    chk("burst_ovf", overflow, 1);
    wait_done("burst");
    chk("burst_ovf_sticky", overflow, 1);

    // Reset during the second digit's request
    req_dly = 20;
    rel_dly = 30;
    tx_vals.delete();
    tx_vals.push_back(12'h1B2);
    send_vals();
    cyc = 0;
    while (rx_q.size() < 2 && cyc < 1000) begin
      @(negedge clock);
      cyc++;
    end
    chk("rst_mid_reach", 32'(cyc >= 1000), 0);
    repeat (5) @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    chk("rst_mid_req", sendRequest, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", sampleReady, 1);
    chk("rst_mid_ovf", overflow, 0);
    cyc = 0;
    while (!sendComplete && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    chk("rst_mid_cpl", 32'(cyc >= 100), 0);
    @(negedge clock);
    resetN = 1'b1;
    rx_q.delete();
    exp_q.delete();
    tx_vals.delete();
    tx_vals.push_back(12'h5C7);
    add_exp(12'h5C7);
    send_vals();
    repeat (3) @(negedge clock);
    chk("post_rst_hold_cpl", sendComplete, 1);
    chk("post_rst_hold_req", sendRequest, 0);
    chk("post_rst_busy", busy, 1);
    wait_done("post_rst");
    chk("post_rst_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
